// File: rtl/keycand_gen.sv
// Brute-force key candidate generator: emits {PREFIX, NVAR alphabet chars} keys
// over valid/ready, one per cycle, with stride/offset partitioning of digit 0.
module keycand_gen #(
  parameter int                  KEY_BITS = 128,
  parameter int                  NVAR     = 6,
  parameter logic [KEY_BITS-1:0] PREFIX   = 128'h68756c6b206973207468_000000000000,
  parameter logic [7:0]          CH_LO    = 8'h41,
  parameter logic [7:0]          CH_HI    = 8'h7A,
  parameter bit                  EXTRA_EN = 1'b1,
  parameter logic [7:0]          EXTRA    = 8'h20,
  parameter int                  STRIDE   = 1,
  parameter int                  COUNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          offset,
  input  logic                abort,
  output logic                key_valid,
  input  logic                key_ready,
  output logic [KEY_BITS-1:0] key,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  key_count
);

  localparam int R   = int'(CH_HI) - int'(CH_LO) + 1 + int'(EXTRA_EN);
  localparam int NCH = R - int'(EXTRA_EN);
  localparam int DW  = 9;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [DW-1:0] dig     [NVAR];
  logic [DW-1:0] dig_adv [NVAR];
  logic [NVAR-1:0] roll;
  logic [DW:0]   t0;
  logic          last;

  genvar gi;

  // roll[k] means digit k wraps on this advance; a digit increments when all
  // lower digits roll, so the carry chain is a plain AND of the lower bits.
  assign t0         = {1'b0, dig[0]} + (DW+1)'(STRIDE);
  assign roll[0]    = t0 >= (DW+1)'(R);
  assign dig_adv[0] = roll[0] ? DW'(t0 - (DW+1)'(R)) : t0[DW-1:0];
  assign last       = &roll;

  generate
    for (gi = 1; gi < NVAR; gi++) begin : g_adv
      assign roll[gi]    = (dig[gi] == DW'(R-1)) & roll[gi-1];
      assign dig_adv[gi] = roll[gi-1] ? ((dig[gi] == DW'(R-1)) ? '0 : dig[gi] + 1'b1)
                                      : dig[gi];
    end

    for (gi = 0; gi < NVAR; gi++) begin : g_char
      assign key[8*(NVAR-1-gi) +: 8] = (dig[gi] < DW'(NCH)) ? CH_LO + dig[gi][7:0] : EXTRA;
    end

    if (KEY_BITS > 8*NVAR) begin : g_prefix
      assign key[KEY_BITS-1:8*NVAR] = PREFIX[KEY_BITS-1:8*NVAR];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_count <= '0;
      for (int i = 0; i < NVAR; i++) dig[i] <= '0;
    end else if (start) begin
      state     <= RUN;
      key_valid <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      key_count <= '0;
      dig[0]    <= DW'(offset);
      for (int i = 1; i < NVAR; i++) dig[i] <= '0;
    end else begin
      case (state)
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            key_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (key_ready) begin
            if (key_count != '1) key_count <= key_count + 1'b1;
            for (int i = 0; i < NVAR; i++) dig[i] <= dig_adv[i];
            if (last) begin
              state     <= DONE;
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keycand_gen.sv
// Scoreboarded random bench for keycand_gen: a base-R counter model predicts keys,
// a negedge monitor pops and compares on every accepted key.
module tb_keycand_gen;

  localparam logic [127:0] PFX_D = 128'h68756c6b206973207468_000000000000;
  localparam logic [127:0] PFX_S = 128'h0;

  logic clk = 1'b0, rst = 1'b1, ready = 1'b0, abort = 1'b0;
  logic start_a = 1'b0, start_p = 1'b0, start_d = 1'b0;
  logic [7:0] off_a = 8'd0, off_d = 8'd0;
  logic [7:0] off_p0 = 8'd0, off_p1 = 8'd1;

  logic kv_a, busy_a, done_a, kv_p0, busy_p0, done_p0, kv_p1, busy_p1, done_p1, kv_d, busy_d, done_d;
  logic [127:0] key_a, key_p0, key_p1, key_d;
  logic [31:0] cnt_a, cnt_p0, cnt_p1, cnt_d;

  logic [127:0] q_a[$], q_p0[$], q_p1[$], q_d[$], got_d[$];
  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  keycand_gen #(.NVAR(2), .PREFIX(PFX_S), .CH_LO(8'h30), .CH_HI(8'h32), .EXTRA_EN(1'b0), .STRIDE(1))
    dut_a (.clk(clk), .rst(rst), .start(start_a), .offset(off_a), .abort(abort), .key_valid(kv_a),
           .key_ready(ready), .key(key_a), .busy(busy_a), .done(done_a), .key_count(cnt_a));
  keycand_gen #(.NVAR(1), .PREFIX(PFX_S), .CH_LO(8'h30), .CH_HI(8'h32), .EXTRA_EN(1'b0), .STRIDE(2))
    dut_p0 (.clk(clk), .rst(rst), .start(start_p), .offset(off_p0), .abort(abort), .key_valid(kv_p0),
            .key_ready(ready), .key(key_p0), .busy(busy_p0), .done(done_p0), .key_count(cnt_p0));
  keycand_gen #(.NVAR(1), .PREFIX(PFX_S), .CH_LO(8'h30), .CH_HI(8'h32), .EXTRA_EN(1'b0), .STRIDE(2))
    dut_p1 (.clk(clk), .rst(rst), .start(start_p), .offset(off_p1), .abort(abort), .key_valid(kv_p1),
            .key_ready(ready), .key(key_p1), .busy(busy_p1), .done(done_p1), .key_count(cnt_p1));
  keycand_gen dut_d (.clk(clk), .rst(rst), .start(start_d), .offset(off_d), .abort(abort), .key_valid(kv_d),
                     .key_ready(ready), .key(key_d), .busy(busy_d), .done(done_d), .key_count(cnt_d));

  // Key number v of the flat space: v written in base R, least significant digit first.
  function automatic logic [127:0] model_key(input logic [127:0] pfx, input int nvar, input int lo,
                                             input int hi, input int xen, input int xch, input longint v);
    int r;
    longint u;
    int d;
    logic [127:0] k;
    r = hi - lo + 1 + xen;
    u = v;
    k = pfx;
    for (int i = 0; i < nvar; i++) begin
      d = int'(u % r);
      u = u / r;
      k[8*(nvar-1-i) +: 8] = (d < r - xen) ? 8'(lo + d) : 8'(xch);
    end
    return k;
  endfunction

  function automatic logic [127:0] kd(input longint v);
    return model_key(PFX_D, 6, 'h41, 'h7a, 1, 'h20, v);
  endfunction

  function automatic logic [127:0] ks(input int nvar, input longint v);
    return model_key(PFX_S, nvar, 'h30, 'h32, 0, 'h20, v);
  endfunction

  task automatic check(input bit ok, input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic pop_check(input int id, input string nm, input logic [127:0] got);
    logic [127:0] e;
    bit have;
    e = '0;
    have = 1'b0;
    case (id)
      0: if (q_a.size() > 0)  begin e = q_a.pop_front();  have = 1'b1; end
      1: if (q_p0.size() > 0) begin e = q_p0.pop_front(); have = 1'b1; end
      2: if (q_p1.size() > 0) begin e = q_p1.pop_front(); have = 1'b1; end
      default: if (q_d.size() > 0) begin e = q_d.pop_front(); have = 1'b1; end
    endcase
    $display("%0t %s accepted key %h", $time, nm, got);
    if (!have) check(have, {nm, "_unexpected_key"}, got, '0);
    else check(got == e, {nm, "_key"}, got, e);
  endtask

  // Monitor: a key counts as accepted when valid&ready with no start/abort overriding it.
  always @(negedge clk) begin
    if (!rst && ready && !abort) begin
      if (kv_a && !start_a) pop_check(0, "a", key_a);
      if (kv_p0 && !start_p) pop_check(1, "p0", key_p0);
      if (kv_p1 && !start_p) pop_check(2, "p1", key_p1);
      if (kv_d && !start_d) begin
        got_d.push_back(key_d);
        pop_check(3, "d", key_d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random(input int n);
    int acc;
    acc = 0;
    for (int i = 0; i < 4000 && acc < n; i++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
      if (ready) acc++;
    end
    ready = 1'b0;
    check(acc == n, "random_run_budget", 128'(acc), 128'(n));
  endtask

  initial begin
    int oa, od, nexp;
    logic [127:0] k0;
    logic [31:0] c0;
    int pat [12];
    pat = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1};

    repeat (2) tick();
    rst = 1'b0;
    tick();
    check(!kv_d && !busy_d && !done_d, "reset_flags_d", {kv_d, busy_d, done_d}, '0);
    check(cnt_d == 0, "reset_count_d", 128'(cnt_d), '0);
    check(key_d == kd(0), "reset_key_d", key_d, kd(0));
    check(key_a == ks(2, 0), "reset_key_a", key_a, ks(2, 0));

    // Exhaustive small space: 9 keys in 9 cycles, then done.
    for (longint v = 0; v < 9; v++) q_a.push_back(ks(2, v));
    off_a = 8'd0; start_a = 1'b1; ready = 1'b1;
    tick();
    start_a = 1'b0;
    check(kv_a && busy_a && !done_a, "a_first_latency", {kv_a, busy_a, done_a}, 128'b110);
    repeat (8) tick();
    check(kv_a && !done_a, "a_ninth_key_valid", {kv_a, done_a}, 128'b10);
    tick();
    check(done_a && !kv_a && !busy_a, "a_done", {done_a, kv_a, busy_a}, 128'b100);
    check(cnt_a == 9, "a_count", 128'(cnt_a), 128'd9);

    // done stays set and no key is offered while key_ready is held.
    for (int i = 0; i < 10; i++) begin
      tick();
      check(done_a && !kv_a, "a_done_sticky", {done_a, kv_a}, 128'b10);
    end

    // Restart from DONE with a random offset.
    oa = $urandom_range(0, 2);
    for (longint v = oa; v < 9; v++) q_a.push_back(ks(2, v));
    off_a = 8'(oa); start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check(!done_a && kv_a && cnt_a == 0, "a_restart", {done_a, kv_a, cnt_a}, 128'h1_00000000);
    for (int i = 0; i < 20 && !done_a; i++) tick();
    check(done_a, "a_restart_done", 128'(done_a), 128'd1);
    check(cnt_a == 32'(9 - oa), "a_restart_count", 128'(cnt_a), 128'(9 - oa));

    // Partitioning: stride 2 over a 3-symbol single-digit space.
    for (longint v = 0; v < 3; v += 2) q_p0.push_back(ks(1, v));
    for (longint v = 1; v < 3; v += 2) q_p1.push_back(ks(1, v));
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    repeat (3) tick();
    check(done_p0 && done_p1 && !kv_p0 && !kv_p1, "p_done", {done_p0, done_p1, kv_p0, kv_p1}, 128'b1100);
    check(cnt_p0 == 2, "p0_count", 128'(cnt_p0), 128'd2);
    check(cnt_p1 == 1, "p1_count", 128'(cnt_p1), 128'd1);
    ready = 1'b0;

    // Default space from offset 0 under random backpressure.
    for (longint v = 0; v < 62; v++) q_d.push_back(kd(v));
    off_d = 8'd0; start_d = 1'b1;
    tick();
    start_d = 1'b0;
    check(kv_d && busy_d, "d_first_latency", {kv_d, busy_d}, 128'b11);
    drive_random(62);
    check(cnt_d == 62, "d_count_62", 128'(cnt_d), 128'd62);
    if (got_d.size() >= 60) begin
      check(got_d[0] == 128'h68756c6b206973207468_414141414141, "d_key0", got_d[0], 128'h68756c6b206973207468_414141414141);
      check(got_d[58] == 128'h68756c6b206973207468_204141414141, "d_key58", got_d[58], 128'h68756c6b206973207468_204141414141);
      check(got_d[59] == 128'h68756c6b206973207468_414241414141, "d_key59", got_d[59], 128'h68756c6b206973207468_414241414141);
    end else check(got_d.size() >= 60, "d_captured", 128'(got_d.size()), 128'd60);

    // Backpressure 1,0,0,1: key and count hold through low cycles.
    for (longint v = 62; v < 68; v++) q_d.push_back(kd(v));
    for (int i = 0; i < 12; i++) begin
      k0 = key_d; c0 = cnt_d;
      ready = pat[i][0];
      tick();
      if (pat[i] == 1) check(cnt_d == c0 + 1, "bp_count_step", 128'(cnt_d), 128'(c0 + 1));
      else check(key_d == k0 && cnt_d == c0, "bp_hold", key_d, k0);
    end
    ready = 1'b0;

    // Start mid-run, coinciding with a handshake that must not count.
    for (longint v = 0; v < 5; v++) q_d.push_back(kd(v));
    off_d = 8'd0; start_d = 1'b1; ready = 1'b1;
    tick();
    start_d = 1'b0;
    check(cnt_d == 0 && kv_d, "restart_count", 128'(cnt_d), '0);
    check(key_d == kd(0), "restart_key", key_d, kd(0));
    repeat (5) tick();
    ready = 1'b0;
    check(cnt_d == 5, "pre_abort_count", 128'(cnt_d), 128'd5);

    // Abort wins over a simultaneous handshake; count is kept.
    abort = 1'b1; ready = 1'b1;
    tick();
    abort = 1'b0; ready = 1'b0;
    check(!kv_d && !busy_d && !done_d, "abort_flags", {kv_d, busy_d, done_d}, '0);
    check(cnt_d == 5, "abort_count", 128'(cnt_d), 128'd5);

    // Random offset run, then asynchronous reset mid-run.
    od = $urandom_range(0, 58);
    for (longint v = od; v < od + 20; v++) q_d.push_back(kd(v));
    off_d = 8'(od); start_d = 1'b1;
    tick();
    start_d = 1'b0;
    drive_random(20);
    nexp = 20;
    check(cnt_d == 32'(nexp), "offset_run_count", 128'(cnt_d), 128'(nexp));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check(!kv_d && !busy_d && !done_d && cnt_d == 0, "async_rst_d", {kv_d, busy_d, done_d, cnt_d}, '0);
    check(key_d == kd(0), "async_rst_key", key_d, kd(0));
    check(!done_a && cnt_a == 0, "async_rst_a", {done_a, cnt_a}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    check(q_a.size() + q_p0.size() + q_p1.size() + q_d.size() == 0, "scoreboard_drained",
          128'(q_a.size() + q_p0.size() + q_p1.size() + q_d.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keycand_gen.md
# keycand_gen

Parametrised brute-force key-candidate generator for the AES key-search datapath. It emits every key of the form {fixed prefix, NVAR variable characters}, where each character is drawn from a configurable alphabet. Keys are delivered over a valid/ready handshake to the decryption core, one per cycle. A stride/offset pair lets several instances partition the key space across parallel cracking channels. A done flag marks exhaustion of the instance's share.

## Interface
- KEY_BITS, 128: key width; multiple of 8.
- NVAR, 6: number of variable characters; 1..KEY_BITS/8.
- PREFIX, 128'h68756c6b206973207468_000000000000: fixed key. Bytes under variable positions are ignored.
- CH_LO, 8'h41: first character of the contiguous alphabet range.
- CH_HI, 8'h7A: last character of the range; CH_HI >= CH_LO.
- EXTRA_EN, 1: 1 appends EXTRA as the last alphabet symbol.
- EXTRA, 8'h20: extra symbol.
- STRIDE, 1: digit-0 step per key; 1..R-1.
- COUNT_W, 32: width of key_count.
- Alphabet size R = CH_HI-CH_LO+1+EXTRA_EN. Defaults give R=59.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- start, in, 1: single-cycle pulse; (re)loads the start state and begins a run.
- offset, in, 8: digit-0 start index, sampled on start; must be < STRIDE for partitioning, and < R.
- abort, in, 1: stop the run and return to IDLE.
- key_valid, out, 1: key holds a candidate.
- key_ready, in, 1: consumer accepts key this cycle.
- key, out, KEY_BITS: candidate key.
- busy, out, 1: FSM is in RUN.
- done, out, 1: the key space of this instance is exhausted; sticky.
- key_count, out, COUNT_W: number of keys accepted since the last start.

## Operation
- Internal state: NVAR digit indices d[0..NVAR-1], each 0..R-1. d[0] changes fastest.
- Index-to-character mapping: i < R-EXTRA_EN gives CH_LO+i; otherwise EXTRA.
- Key layout: the upper KEY_BITS-8*NVAR bits come from PREFIX. The variable bytes follow MSB-first: char(d[0]) occupies the byte adjacent to the prefix, and char(d[NVAR-1]) occupies key[7:0].
- Advance step:
  - t = d[0]+STRIDE. If t >= R, then d[0] = t-R and carry = 1; otherwise d[0] = t.
  - For k >= 1, d[k] += carry with wrap at R. Carry propagates.
  - Carry out of d[NVAR-1] means the last key of the space.
- FSM states:
  - IDLE: key_valid=0. start loads d[0]=offset, d[k>0]=0, key_count=0, done=0, then goes to RUN.
  - RUN: key_valid=1. On a handshake (key_valid&key_ready), key_count increments (saturating at all-ones) and the digits advance. If that advance carries out, go to DONE.
  - RUN, abort=1: go to IDLE; digits hold.
  - DONE: key_valid=0, done=1. Hold until start (reload, go to RUN) or rst.
- Priority: rst > start > abort > handshake.
  - start in any state restarts the run, including mid-run and the same cycle as a handshake. The accepted key is not counted.
- key_count is never cleared by abort.

## Timing
- Reset values:
  - key_valid=0, busy=0, done=0, key_count=0.
  - All digits 0, so key = prefix followed by NVAR copies of CH_LO.
- Latency: start sampled at edge N. key_valid=1 with the first key is visible after edge N.
- Throughput: one key per cycle while key_ready=1.
- key is stable while key_valid=1 and key_ready=0.
- Last key accepted at edge M: done=1 and key_valid=0 after edge M.
- All outputs are registered, with no combinational path from key_ready to key_valid or key.
- Reset asserted mid-run: everything returns to reset values immediately, asynchronously.

## Test plan
- Exhaustive small space. Parameters: NVAR=2, CH_LO=8'h30, CH_HI=8'h32, EXTRA_EN=0, PREFIX of all zeros in the upper bytes.
  - Stimulus: start with offset=0, key_ready held at 1.
  - Required: keys 3030, 3130, 3230, 3031 … 3232, 9 keys in 9 cycles. done=1 on the next cycle; key_count=9.
- Default parameters, extra symbol and carry.
  - Stimulus: run from reset with start.
  - Required: first key = 68756c6b206973207468_414141414141. Key 58 has d0 char 0x20. Key 59 = …_414241414141.
- Partitioning.
  - Stimulus: two instances with STRIDE=2, offset 0 and 1, on the small space above with NVAR=1.
  - Required: instance 0 emits 30, 32. Instance 1 emits 31. Both assert done; key_counts are 2 and 1.
- Backpressure.
  - Stimulus: key_ready toggles 1,0,0,1.
  - Required: key is unchanged during the low cycles, and key_count advances only on the high cycles.
- Control.
  - Stimulus: abort after 5 keys.
  - Required: busy=0, key_valid=0, key_count stays 5.
  - Stimulus: start mid-run.
  - Required: the first key reappears and key_count=0.
  - Stimulus: rst mid-run.
  - Required: all outputs return to their reset values.
- done stickiness.
  - Stimulus: after done, hold key_ready=1 for 10 cycles.
  - Required: no key_valid; done stays 1 until the next start.
